// File: rtl/rtc_burst_if.sv
// Burst controller for a multiplexed-address/data RTC bus: each element runs
// an address phase, a fixed gap, then a read or write data strobe.
module rtc_burst_if #(
  parameter int DW        = 8,
  parameter int ADDR_CYC  = 5,
  parameter int GAP_CYC   = 8,
  parameter int DATA_CYC  = 5,
  parameter int MAX_BURST = 8,
  localparam int IW = $clog2(MAX_BURST),
  localparam int LW = IW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [DW-1:0] base_addr,
  input  logic [LW-1:0] burst_len,
  input  logic          wbuf_we,
  input  logic [IW-1:0] wbuf_idx,
  input  logic [DW-1:0] wbuf_data,
  input  logic [IW-1:0] rbuf_idx,
  output logic [DW-1:0] rbuf_data,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          ad,
  output logic          cs,
  output logic          wr,
  output logic          rd,
  output logic          busy,
  output logic          done,
  output logic          ready,
  output logic          err
);

  localparam int CW = $clog2(ADDR_CYC + GAP_CYC + DATA_CYC + 1);

  localparam logic [3:0] S_IDLE  = 4'd0,  S_A_ALE = 4'd1,  S_A_CS  = 4'd2,
                         S_A_DRV = 4'd3,  S_A_WRH = 4'd4,  S_A_CSH = 4'd5,
                         S_A_ADH = 4'd6,  S_GAP   = 4'd7,  S_D_CS  = 4'd8,
                         S_D_STB = 4'd9,  S_D_END = 4'd10, S_DONE  = 4'd11;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic          op_q, op_d;

  logic          ad_q, cs_q, wr_q, rd_q, oe_q, busy_q, done_q, ready_q, err_q;
  logic          ad_d, cs_d, wr_d, rd_d, oe_d, busy_d, done_d, ready_d, err_d;
  logic [DW-1:0] bus_out_q, bus_out_d;

  logic [DW-1:0] wbuf_mem [MAX_BURST];
  logic [DW-1:0] rbuf_mem [MAX_BURST];

  logic len_ok, last_elem, accept, drv_addr, strobe, strobe_last;

  assign len_ok      = (burst_len != '0) && (burst_len <= LW'(MAX_BURST));
  assign last_elem   = (LW'(idx_q) + LW'(1)) == len_q;
  assign strobe_last = (state_q == S_D_STB) && (cnt_q == CW'(DATA_CYC - 1));

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    op_d    = op_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (start && len_ok) begin
        accept  = 1'b1;
        state_d = S_A_ALE;
        op_d    = op;
        addr_d  = base_addr;
        len_d   = burst_len;
        idx_d   = '0;
        cnt_d   = '0;
      end
      S_A_ALE: state_d = S_A_CS;
      S_A_CS:  state_d = S_A_DRV;
      S_A_DRV: if (cnt_q == CW'(ADDR_CYC - 1)) begin
        cnt_d   = '0;
        state_d = S_A_WRH;
      end else cnt_d = cnt_q + CW'(1);
      S_A_WRH: state_d = S_A_CSH;
      S_A_CSH: state_d = S_A_ADH;
      S_A_ADH: state_d = S_GAP;
      S_GAP: if (cnt_q == CW'(GAP_CYC - 1)) begin
        cnt_d   = '0;
        state_d = S_D_CS;
      end else cnt_d = cnt_q + CW'(1);
      S_D_CS:  state_d = S_D_STB;
      S_D_STB: if (strobe_last) begin
        cnt_d   = '0;
        state_d = S_D_END;
      end else cnt_d = cnt_q + CW'(1);
      S_D_END: if (last_elem) state_d = S_DONE;
      else begin
        idx_d   = idx_q + IW'(1);
        addr_d  = addr_q + DW'(1);
        state_d = S_A_ALE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    drv_addr = (state_d == S_A_DRV);
    strobe   = (state_d == S_D_STB);
    ad_d     = !(state_d inside {S_A_ALE, S_A_CS, S_A_DRV, S_A_WRH, S_A_CSH});
    cs_d     = !(state_d inside {S_A_CS, S_A_DRV, S_A_WRH, S_D_CS, S_D_STB});
    wr_d     = !(drv_addr || (strobe && op_d));
    rd_d     = !(strobe && !op_d);
    oe_d     = !wr_d;
    if (drv_addr)
      bus_out_d = addr_q;
    else if (strobe && op_d)
      // Write data is latched on entry to the strobe, so a mid-strobe host write waits a burst.
      bus_out_d = (state_q == S_D_STB) ? bus_out_q : wbuf_mem[idx_q];
    else
      bus_out_d = '1;
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    ready_d = done_d ? 1'b1 : (accept ? 1'b0 : ready_q);
    err_d   = start && !accept;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      op_q      <= 1'b0;
      ad_q      <= 1'b1;
      cs_q      <= 1'b1;
      wr_q      <= 1'b1;
      rd_q      <= 1'b1;
      oe_q      <= 1'b0;
      bus_out_q <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      op_q      <= op_d;
      ad_q      <= ad_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      oe_q      <= oe_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // NOTE: buffer memories are deliberately not reset; reset only blocks writes that cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wbuf_we) wbuf_mem[wbuf_idx] <= wbuf_data;
      if (strobe_last && !op_q) rbuf_mem[idx_q] <= bus_in;
    end
  end

  assign rbuf_data = rbuf_mem[rbuf_idx];
  assign bus_out   = bus_out_q;
  assign bus_oe    = oe_q;
  assign ad        = ad_q;
  assign cs        = cs_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ready     = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rtc_burst_if.sv
// Self-checking bench for rtc_burst_if: a phase-table model of the bus protocol
// is compared against the pins every cycle, plus directed literal checks.
module tb_rtc_burst_if;

  localparam int A    = 5;
  localparam int G    = 8;
  localparam int D    = 5;
  localparam int ELEM = 7 + A + G + D;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] base_addr = '0;
  logic [3:0] burst_len = '0;
  logic       wbuf_we = 1'b0;
  logic [2:0] wbuf_idx = '0;
  logic [7:0] wbuf_data = '0;
  logic [2:0] rbuf_idx = '0;
  logic [7:0] rbuf_data;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe, ad, cs, wr, rd, busy, done, ready, err;

  rtc_burst_if dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
    .burst_len(burst_len), .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx), .wbuf_data(wbuf_data),
    .rbuf_idx(rbuf_idx), .rbuf_data(rbuf_data), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oe(bus_oe), .ad(ad), .cs(cs), .wr(wr), .rd(rd), .busy(busy), .done(done),
    .ready(ready), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Bus device: remembers the last driven address and answers reads with address+1.
  logic [7:0] dev_addr = '0;
  always @(negedge clock) if (!ad && bus_oe) dev_addr = bus_out;
  assign bus_in = dev_addr + 8'd1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state, written only by the stimulus process.
  bit         chk_en = 1'b0;
  bit         mdl_valid = 1'b0;
  bit         mdl_ready_base = 1'b0;
  int         mdl_t0 = 0;
  int         mdl_err_at = -100;
  bit         mdl_op = 1'b0;
  logic [7:0] mdl_base = '0;
  int         mdl_len = 0;
  logic [7:0] mdl_wbuf [8];

  int         k, el, ph, done_k;
  logic       e_ad, e_cs, e_wr, e_rd, e_oe, e_busy, e_done, e_ready, e_err;
  logic [7:0] e_bus;
  bit         in_drv, in_stb;

  always @(negedge clock) begin
    if (chk_en) begin
      e_ad = 1; e_cs = 1; e_wr = 1; e_rd = 1; e_oe = 0; e_bus = 8'hFF;
      e_busy = 0; e_done = 0; e_ready = mdl_ready_base;
      e_err = (cyc == mdl_err_at);
      if (mdl_valid) begin
        k      = cyc - mdl_t0 + 1;
        done_k = ELEM * mdl_len + 1;
        e_ready = (k >= done_k);
        if (k == done_k) e_done = 1;
        else if (k < done_k) begin
          el = (k - 1) / ELEM;
          ph = (k - 1) % ELEM;
          e_busy = 1;
          in_drv = (ph >= 2) && (ph <= 1 + A);
          in_stb = (ph >= 6 + A + G) && (ph <= 5 + A + G + D);
          e_ad = !(ph <= 3 + A);
          e_cs = !(((ph >= 1) && (ph <= 2 + A)) || ((ph >= 5 + A + G) && (ph <= 5 + A + G + D)));
          e_wr = !(in_drv || (in_stb && mdl_op));
          e_rd = !(in_stb && !mdl_op);
          e_oe = in_drv || (in_stb && mdl_op);
          if (in_drv) e_bus = mdl_base + 8'(el);
          else if (in_stb && mdl_op) e_bus = mdl_wbuf[el];
        end
      end
      check("pins", {15'd0, ad, cs, wr, rd, bus_oe, busy, done, ready, err, bus_out},
            {15'd0, e_ad, e_cs, e_wr, e_rd, e_oe, e_busy, e_done, e_ready, e_err, e_bus});
      check("inv_rd_wr", 32'(rd | wr), 32'd1);
      check("inv_oe_wr", 32'(!(bus_oe && wr)), 32'd1);
      check("inv_cs_busy", 32'(!(!cs && !busy)), 32'd1);
    end
  end

  // Every stimulus task starts and ends 1 time unit after a rising edge.
  task automatic wbuf_load(input logic [2:0] idx, input logic [7:0] data);
    wbuf_we = 1'b1; wbuf_idx = idx; wbuf_data = data;
    @(posedge clock); #1;
    wbuf_we = 1'b0;
    mdl_wbuf[idx] = data;
  endtask

  task automatic do_start(input bit o, input logic [7:0] base, input int len);
    start = 1'b1; op = o; base_addr = base; burst_len = 4'(len);
    @(posedge clock); #1;
    start = 1'b0;
    mdl_valid = 1'b1; mdl_t0 = cyc; mdl_op = o; mdl_base = base; mdl_len = len;
  endtask

  task automatic rejected_start(input int len);
    start = 1'b1; op = 1'b1; base_addr = 8'h55; burst_len = 4'(len);
    @(posedge clock); #1;
    start = 1'b0;
    mdl_err_at = cyc;
  endtask

  logic [7:0] addr_seen [$];

  task automatic wait_done(input logic [7:0] va, input logic [7:0] vd,
                           output int edges, output int na, output int nd);
    bit prev_a;
    edges = 0; na = 0; nd = 0; prev_a = 0;
    addr_seen.delete();
    while (edges < 400) begin
      @(posedge clock); edges++;
      @(negedge clock);
      if (!wr && bus_out == va) na++;
      if (!wr && bus_out == vd) nd++;
      if (!ad && !wr && !prev_a) addr_seen.push_back(bus_out);
      prev_a = !ad && !wr;
      if (done) break;
    end
    check("done_seen", 32'(done), 32'd1);
    @(posedge clock); #1;
  endtask

  int edges, na, nd;
  logic [7:0] exp_rb [3] = '{8'h0B, 8'h0C, 8'h0D};

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Single-element write.
    wbuf_load(3'd0, 8'h12);
    do_start(1'b1, 8'h23, 1);
    wait_done(8'h23, 8'h12, edges, na, nd);
    check("wr1_done_edge", 32'(edges), 32'd25);
    check("wr1_addr_cycles", 32'(na), 32'd5);
    check("wr1_data_cycles", 32'(nd), 32'd5);

    // Three-element read with an ignored start in the middle.
    do_start(1'b0, 8'h0A, 3);
    repeat (9) begin @(posedge clock); #1; end
    start = 1'b1; op = 1'b1; base_addr = 8'h77; burst_len = 4'd2;
    @(posedge clock); #1;
    start = 1'b0;
    mdl_err_at = cyc;
    wait_done(8'hEE, 8'hEE, edges, na, nd);
    check("rd3_done_edge", 32'(10 + edges), 32'd75);
    check("rd3_ready", 32'(ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rbuf_idx = 3'(i);
      #1;
      check("rd3_rbuf", 32'(rbuf_data), 32'(exp_rb[i]));
    end

    // Illegal lengths: err pulse, strobes idle, ready kept.
    rejected_start(0);
    @(negedge clock);
    check("len0_err", 32'(err), 32'd1);
    check("len0_strobes", 32'({ad, cs, wr, rd}), 32'hF);
    check("len0_ready", 32'(ready), 32'd1);
    @(posedge clock); #1;
    rejected_start(9);
    @(negedge clock);
    check("len9_err", 32'(err), 32'd1);
    check("len9_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;

    // Reset beats a buffer write and a start in the same cycle.
    reset = 1'b1; wbuf_we = 1'b1; wbuf_idx = 3'd0; wbuf_data = 8'h99;
    start = 1'b1; op = 1'b1; base_addr = 8'h01; burst_len = 4'd1;
    @(posedge clock); #1;
    reset = 1'b0; wbuf_we = 1'b0; start = 1'b0;
    mdl_valid = 1'b0; mdl_ready_base = 1'b0;

    // Address wrap on a write burst; element 0 must still carry 0x12.
    wbuf_load(3'd1, 8'h34);
    wbuf_load(3'd2, 8'h56);
    do_start(1'b1, 8'hFE, 3);
    wait_done(8'hFE, 8'h12, edges, na, nd);
    check("wrap_done_edge", 32'(edges), 32'd75);
    check("wrap_addr_count", 32'(addr_seen.size()), 32'd3);
    if (addr_seen.size() == 3) begin
      check("wrap_addr0", 32'(addr_seen[0]), 32'hFE);
      check("wrap_addr1", 32'(addr_seen[1]), 32'hFF);
      check("wrap_addr2", 32'(addr_seen[2]), 32'h00);
    end
    check("wrap_wbuf0_kept", 32'(nd), 32'd5);

    // Reset in the data strobe of the second read element.
    do_start(1'b0, 8'h40, 3);
    repeat (46) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    mdl_valid = 1'b0; mdl_ready_base = 1'b0;
    @(negedge clock);
    check("rst_strobes", 32'({ad, cs, wr, rd}), 32'hF);
    check("rst_oe", 32'(bus_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rbuf_idx = 3'd0;
    #1 check("rst_rbuf0", 32'(rbuf_data), 32'h41);
    rbuf_idx = 3'd1;
    #1 check("rst_rbuf1_kept", 32'(rbuf_data), 32'h0C);
    repeat (3) @(posedge clock);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
